// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start, 4 data bits MSB first, optional even parity, stop.
// Line idles low; start is high, stop is low.
module serial_frame_tx #(
    parameter int BIT_CYCLES = 4,
    parameter bit PARITY_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       ser_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [1:0] idx, idx_n;
    logic [3:0] shreg, shreg_n;
    logic       par, par_n;
    logic       ser_n;
    logic       tc;

    assign tc    = (cnt == LAST);
    assign ready = (state == IDLE);
    assign busy  = (state != IDLE);
    assign done  = (state == STOP) && tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            idx     <= 2'd0;
            shreg   <= 4'd0;
            par     <= 1'b0;
            ser_out <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            par     <= par_n;
            ser_out <= ser_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        par_n   = par;
        ser_n   = 1'b0;

        if (state != IDLE) begin
            cnt_n = tc ? 8'd0 : cnt + 8'd1;
        end

        case (state)
            IDLE: begin
                if (valid) begin
                    state_n = START;
                    cnt_n   = 8'd0;
                    idx_n   = 2'd3;
                    shreg_n = data_in;
                    par_n   = ^data_in;
                end
            end
            START: begin
                if (tc) begin
                    state_n = DATA;
                    idx_n   = 2'd3;
                end
            end
            DATA: begin
                if (tc) begin
                    if (idx == 2'd0) begin
                        state_n = PARITY_EN ? PARITY : STOP;
                    end else begin
                        idx_n = idx - 2'd1;
                    end
                end
            end
            PARITY: begin
                if (tc) state_n = STOP;
            end
            STOP: begin
                if (tc) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Line value is registered, so it follows the state being entered.
        case (state_n)
            START:   ser_n = 1'b1;
            DATA:    ser_n = shreg_n[idx_n];
            PARITY:  ser_n = par_n;
            default: ser_n = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: default instance plus a
// parity-off, one-cycle-per-bit instance.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic       valid = 1'b0;
    logic       ready, ser_out, busy, done;
    logic [3:0] data_in1 = 4'd0;
    logic       valid1 = 1'b0;
    logic       ready1, ser_out1, busy1, done1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_frame_tx u0 (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    serial_frame_tx #(.BIT_CYCLES(1), .PARITY_EN(1'b0)) u1 (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in1),
        .valid   (valid1),
        .ready   (ready1),
        .ser_out (ser_out1),
        .busy    (busy1),
        .done    (done1)
    );

    // Observed vectors are {ser_out, busy, done, ready}; sampled 1 unit after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] obs, obs1;
        rst = 1'b1;
        valid = 1'b0;
        valid1 = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            obs  = {ser_out, busy, done, ready};
            obs1 = {ser_out1, busy1, done1, ready1};
            checks++;
            if (obs !== 4'b0001) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=0001", k, obs);
            end
            checks++;
            if (obs1 !== 4'b0001) begin
                errors++;
                $display("FAIL reset_idle_u1 cyc=%0d got=%b exp=0001", k, obs1);
            end
            step();
        end
    endtask

    task automatic test_basic_frame();
        logic [6:0] fb;
        logic [3:0] obs, exp;
        fb = 7'b1101110;
        data_in = 4'b1011;
        valid = 1'b1;
        step();
        valid = 1'b0;
        data_in = 4'b0000;
        for (int k = 0; k < 28; k++) begin
            obs = {ser_out, busy, done, ready};
            exp = {fb[6 - k / 4], 1'b1, k == 27, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL basic_frame cyc=%0d got=%b exp=%b", k, obs, exp);
            end
            step();
        end
        obs = {ser_out, busy, done, ready};
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL basic_frame_end got=%b exp=0001", obs);
        end
        step();
    endtask

    task automatic test_data_change();
        logic [6:0] fb;
        logic [3:0] obs, exp;
        data_in = 4'b0110;
        valid = 1'b1;
        step();
        data_in = 4'b1111;
        fb = 7'b1011000;
        for (int k = 0; k < 28; k++) begin
            obs = {ser_out, busy, done, ready};
            exp = {fb[6 - k / 4], 1'b1, k == 27, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL data_change cyc=%0d got=%b exp=%b", k, obs, exp);
            end
            step();
        end
        obs = {ser_out, busy, done, ready};
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL data_change_gap got=%b exp=0001", obs);
        end
        step();
        valid = 1'b0;
        fb = 7'b1111100;
        for (int k = 0; k < 28; k++) begin
            obs = {ser_out, busy, done, ready};
            exp = {fb[6 - k / 4], 1'b1, k == 27, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL data_change_2nd cyc=%0d got=%b exp=%b", k, obs, exp);
            end
            step();
        end
        obs = {ser_out, busy, done, ready};
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL data_change_end got=%b exp=0001", obs);
        end
        step();
    endtask

    task automatic test_reset_mid_frame();
        logic [6:0] fb;
        logic [3:0] obs, exp;
        data_in = 4'b1001;
        valid = 1'b1;
        step();
        valid = 1'b0;
        fb = 7'b1100100;
        for (int k = 0; k < 10; k++) begin
            obs = {ser_out, busy, done, ready};
            exp = {fb[6 - k / 4], 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", k, obs, exp);
            end
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            obs = {ser_out, busy, done, ready};
            checks++;
            if (obs !== 4'b0001) begin
                errors++;
                $display("FAIL reset_mid_idle cyc=%0d got=%b exp=0001", k, obs);
            end
            step();
        end
        // Reset and valid together: reset must win.
        rst = 1'b1;
        valid = 1'b1;
        data_in = 4'b1111;
        step();
        rst = 1'b0;
        valid = 1'b0;
        obs = {ser_out, busy, done, ready};
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL reset_wins got=%b exp=0001", obs);
        end
        step();
        data_in = 4'b0101;
        valid = 1'b1;
        step();
        valid = 1'b0;
        fb = 7'b1010100;
        for (int k = 0; k < 28; k++) begin
            obs = {ser_out, busy, done, ready};
            exp = {fb[6 - k / 4], 1'b1, k == 27, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_recover cyc=%0d got=%b exp=%b", k, obs, exp);
            end
            step();
        end
        obs = {ser_out, busy, done, ready};
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL reset_recover_end got=%b exp=0001", obs);
        end
        step();
    endtask

    task automatic test_no_parity_fast();
        logic [5:0] fb;
        logic [3:0] obs, exp;
        data_in1 = 4'b0000;
        valid1 = 1'b1;
        step();
        valid1 = 1'b0;
        fb = 6'b100000;
        for (int k = 0; k < 6; k++) begin
            obs = {ser_out1, busy1, done1, ready1};
            exp = {fb[5 - k], 1'b1, k == 5, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL no_parity cyc=%0d got=%b exp=%b", k, obs, exp);
            end
            step();
        end
        obs = {ser_out1, busy1, done1, ready1};
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL no_parity_end got=%b exp=0001", obs);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [13:0] fb;
        logic [3:0]  obs, exp;
        data_in = 4'b1100;
        valid = 1'b1;
        step();
        data_in = 4'b0011;
        fb = {7'b1110000, 7'b1001100};
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 28; k++) begin
                obs = {ser_out, busy, done, ready};
                exp = {fb[13 - 7 * f - k / 4], 1'b1, k == 27, 1'b0};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL b2b f=%0d cyc=%0d got=%b exp=%b", f, k, obs, exp);
                end
                step();
            end
            obs = {ser_out, busy, done, ready};
            checks++;
            if (obs !== 4'b0001) begin
                errors++;
                $display("FAIL b2b_gap f=%0d got=%b exp=0001", f, obs);
            end
            if (f == 1) valid = 1'b0;
            step();
        end
        obs = {ser_out, busy, done, ready};
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_end got=%b exp=0001", obs);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic_frame();
        test_data_change();
        test_reset_mid_frame();
        test_no_parity_fast();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
